// File: rtl/pc_sequencer.sv
// Next-address controller for the fetch path: stall/jump/branch/sequential
// selection plus interrupt entry, return and the EPC/pending bookkeeping.
module pc_sequencer #(
  parameter logic [31:0] PC_STEP    = 32'd1,
  parameter logic [31:0] VEC_P0     = 32'd0,
  parameter logic [31:0] VEC_P1     = 32'd15,
  parameter logic [31:0] VEC_P3     = 32'd25,
  parameter logic [31:0] IRQ_VECTOR = 32'd40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  progr,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        eret,
  input  logic        interrupt,
  output logic [31:0] next_address,
  output logic [31:0] epc,
  output logic        in_isr,
  output logic        irq_ack,
  output logic        irq_overrun
);

  typedef enum logic [1:0] {
    RUN = 2'd0,
    ISR = 2'd1,
    RET = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        pending_q, pending_d;
  logic        irq_prev_q;
  logic [31:0] epc_q, epc_d;
  logic        in_isr_q, in_isr_d;
  logic        ack_q, ack_d;
  logic        ovr_q, ovr_d;

  logic        irq_edge;
  logic        take;
  logic [31:0] seq;
  logic [31:0] norm;
  logic [31:0] vec;

  assign irq_edge = interrupt & ~irq_prev_q;
  assign seq      = pc + PC_STEP;
  assign norm     = jump ? jump_target
                  : branch_taken ? branch_target
                  : seq;

  always_comb begin
    vec = VEC_P0;
    unique case (progr)
      2'b01:   vec = VEC_P1;
      2'b11:   vec = VEC_P3;
      default: vec = VEC_P0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    next_address = norm;
    take         = 1'b0;
    epc_d        = epc_q;
    in_isr_d     = in_isr_q;
    if (reset) begin
      next_address = vec;
    end else begin
      case (state_q)
        RUN: begin
          if (stall) begin
            next_address = pc;
          end else if (pending_q) begin
            next_address = IRQ_VECTOR;
            take         = 1'b1;
            epc_d        = norm;
            in_isr_d     = 1'b1;
            state_d      = ISR;
          end
        end
        ISR: begin
          if (stall) begin
            next_address = pc;
          end else if (eret) begin
            next_address = epc_q;
            in_isr_d     = 1'b0;
            state_d      = RET;
          end
        end
        RET: begin
          if (stall) next_address = pc;
          else       state_d      = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // A take consumes the pending edge; a same-cycle edge re-arms it cleanly.
  always_comb begin
    pending_d = take ? irq_edge : (pending_q | irq_edge);
    ovr_d     = ovr_q | (irq_edge & pending_q & ~take);
    ack_d     = take;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      pending_q  <= 1'b0;
      irq_prev_q <= 1'b0;
      epc_q      <= '0;
      in_isr_q   <= 1'b0;
      ack_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      irq_prev_q <= interrupt;
      epc_q      <= epc_d;
      in_isr_q   <= in_isr_d;
      ack_q      <= ack_d;
      ovr_q      <= ovr_d;
    end
  end

  assign epc         = epc_q;
  assign in_isr      = in_isr_q;
  assign irq_ack     = ack_q;
  assign irq_overrun = ovr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table for fetch selection
// plus hand sequences for interrupt entry, return, overrun and reset.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  progr;
  logic [31:0] pc;
  logic        stall;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        eret;
  logic        interrupt;
  logic [31:0] next_address;
  logic [31:0] epc;
  logic        in_isr;
  logic        irq_ack;
  logic        irq_overrun;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pc_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .progr         (progr),
    .pc            (pc),
    .stall         (stall),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .eret          (eret),
    .interrupt     (interrupt),
    .next_address  (next_address),
    .epc           (epc),
    .in_isr        (in_isr),
    .irq_ack       (irq_ack),
    .irq_overrun   (irq_overrun)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  prg;
    logic [31:0] pc;
    logic        stl;
    logic        jmp;
    logic [31:0] jt;
    logic        br;
    logic [31:0] bt;
    logic        ert;
    logic [31:0] exp_na;
    string       name;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle();
    reset = 0; progr = 0; pc = 0; stall = 0; jump = 0;
    jump_target = 0; branch_taken = 0; branch_target = 0;
    eret = 0;
  endtask

  // check combinational next_address mid-cycle, then advance one clock
  task automatic step(input string nm, input logic [31:0] exp);
    #4;
    chk(nm, next_address, exp);
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    interrupt = 0;
    reset = 1;
    @(posedge clock);
    #1;
    chk("rst_epc", epc, 32'h0);
    chk("rst_in_isr", {31'b0, in_isr}, 32'h0);
    chk("rst_ack", {31'b0, irq_ack}, 32'h0);
    chk("rst_ovr", {31'b0, irq_overrun}, 32'h0);

    vt.push_back('{1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 32'd15, "vec_p1"});
    vt.push_back('{1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 32'd25, "vec_p3"});
    vt.push_back('{1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 32'd0, "vec_p2"});
    vt.push_back('{1, 2'b00, 9, 0, 0, 0, 0, 0, 0, 32'd0, "vec_p0"});
    vt.push_back('{0, 2'b00, 15, 0, 0, 0, 0, 0, 0, 32'd16, "seq"});
    vt.push_back('{0, 2'b00, 32'h100, 0, 1, 32'h300, 1, 32'h200, 0,
                   32'h300, "jmp_over_br"});
    vt.push_back('{0, 2'b00, 32'h100, 0, 0, 32'h300, 1, 32'h200, 0,
                   32'h200, "branch"});
    vt.push_back('{0, 2'b00, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0,
                   32'h0, "wrap"});
    vt.push_back('{0, 2'b00, 32'h55, 1, 1, 32'h300, 0, 0, 0,
                   32'h55, "stall"});
    vt.push_back('{0, 2'b00, 32'h10, 0, 0, 0, 0, 0, 1,
                   32'h11, "eret_in_run"});

    foreach (vt[i]) begin
      reset = vt[i].rst; progr = vt[i].prg; pc = vt[i].pc;
      stall = vt[i].stl; jump = vt[i].jmp; jump_target = vt[i].jt;
      branch_taken = vt[i].br; branch_target = vt[i].bt;
      eret = vt[i].ert;
      step(vt[i].name, vt[i].exp_na);
    end

    // interrupt entry and return
    idle();
    pc = 32'h20; interrupt = 1;
    step("irq_edge_cycle", 32'h21);
    step("irq_entry", 32'd40);
    chk("epc_saved", epc, 32'h21);
    chk("ack_high", {31'b0, irq_ack}, 32'h1);
    chk("in_isr_high", {31'b0, in_isr}, 32'h1);
    pc = 32'd40; interrupt = 0;
    step("isr_seq", 32'd41);
    chk("ack_pulse", {31'b0, irq_ack}, 32'h0);
    pc = 32'h2A; eret = 1;
    step("eret", 32'h21);
    chk("in_isr_clr", {31'b0, in_isr}, 32'h0);
    pc = 32'h21; eret = 0;
    step("ret_cycle", 32'h22);

    // edge while in ISR waits until after the RET cycle
    pc = 32'h50; interrupt = 1;
    step("edge2", 32'h51);
    interrupt = 0;
    step("entry2", 32'd40);
    pc = 32'd40; interrupt = 1;
    step("isr_masked", 32'd41);
    interrupt = 0; pc = 32'h45; eret = 1;
    step("eret2", 32'h51);
    eret = 0; pc = 32'h51;
    step("ret_normal", 32'h52);
    pc = 32'h52;
    step("deferred_entry", 32'd40);
    chk("ack_deferred", {31'b0, irq_ack}, 32'h1);
    chk("epc_deferred", epc, 32'h53);

    // reset in the middle of a handler with an edge pending
    pc = 32'd40; interrupt = 1;
    step("isr_pend", 32'd41);
    interrupt = 0; reset = 1; progr = 2'b01;
    step("mid_isr_reset", 32'd15);
    reset = 0; progr = 0; pc = 32'd15;
    chk("reset_epc", epc, 32'h0);
    chk("reset_in_isr", {31'b0, in_isr}, 32'h0);
    step("post_reset", 32'd16);
    pc = 32'd16;
    step("pending_dropped", 32'd17);

    // overrun: second edge while the first is still pending
    pc = 32'h70; stall = 1; interrupt = 1;
    step("ovr_e1", 32'h70);
    interrupt = 0;
    step("ovr_gap", 32'h70);
    chk("ovr_not_yet", {31'b0, irq_overrun}, 32'h0);
    interrupt = 1;
    step("ovr_e2", 32'h70);
    chk("ovr_set", {31'b0, irq_overrun}, 32'h1);
    step("stall_pending", 32'h70);
    stall = 0;
    step("ovr_entry", 32'd40);
    chk("ovr_sticky", {31'b0, irq_overrun}, 32'h1);
    chk("ovr_in_isr", {31'b0, in_isr}, 32'h1);
    chk("ovr_epc", epc, 32'h71);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
